disp_scan_ctrl: RTL and testbench



---
 rtl/disp_scan_ctrl.sv | 129 ++++++++++++
 tb/tb_disp_scan_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/disp_scan_ctrl.sv
// Scan controller for a multiplexed common-anode 7-seg display; LEADING_ZERO_BLANK_EN adds leading-zero suppression.
// Latency: outputs registered from next-state scan position; staged loads commit at the next frame boundary.
// Backpressure: none, load is always accepted and a newer load overwrites an uncommitted one.
module disp_scan_ctrl #(
    parameter int N_DIGITS     = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 2000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*N_DIGITS-1:0]   value,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic [N_DIGITS-1:0]     digit_en,
    input  logic                    load,
    output logic                    load_ack,
    output logic [3:0]              hex_out,
    output logic [N_DIGITS-1:0]     an,
    output logic                    dp_n
);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(N_DIGITS);
    localparam logic [PW-1:0] PCNT_MAX  = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_MAX   = IW'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] ONE_HOT0 = {{(N_DIGITS-1){1'b0}}, 1'b1};

    logic [PW-1:0]           pcnt, pcnt_nxt;
    logic [IW-1:0]           idx, idx_nxt;
    logic                    pending, pending_nxt;
    logic [4*N_DIGITS-1:0]   stg_val, stg_val_nxt, shd_val, shd_val_nxt;
    logic [N_DIGITS-1:0]     stg_dp, stg_dp_nxt, shd_dp, shd_dp_nxt;
    logic [N_DIGITS-1:0]     stg_en, stg_en_nxt, shd_en, shd_en_nxt;
    logic                    wrap, frame_end;
    logic                    ack_nxt, dp_n_nxt, blank_dig;
    logic [3:0]              hex_nxt;
    logic [N_DIGITS-1:0]     an_nxt;
`ifdef LEADING_ZERO_BLANK_EN
    logic [N_DIGITS-1:0]     lz;
    logic                    zero_run;
`endif

    always_comb begin
        wrap        = (pcnt == PCNT_MAX);
        frame_end   = wrap && (idx == IDX_MAX);
        pcnt_nxt    = wrap ? '0 : pcnt + 1'b1;
        idx_nxt     = idx;
        if (wrap)
            idx_nxt = (idx == IDX_MAX) ? '0 : idx + 1'b1;

        stg_val_nxt = stg_val;
        stg_dp_nxt  = stg_dp;
        stg_en_nxt  = stg_en;
        shd_val_nxt = shd_val;
        shd_dp_nxt  = shd_dp;
        shd_en_nxt  = shd_en;
        pending_nxt = pending;
        ack_nxt     = 1'b0;

        if (load) begin
            stg_val_nxt = value;
            stg_dp_nxt  = dp_in;
            stg_en_nxt  = digit_en;
            pending_nxt = 1'b1;
        end
        // A load landing on the boundary edge bypasses staging so it is never a frame late.
        if (frame_end && load) begin
            shd_val_nxt = value;
            shd_dp_nxt  = dp_in;
            shd_en_nxt  = digit_en;
            pending_nxt = 1'b0;
            ack_nxt     = 1'b1;
        end else if (frame_end && pending) begin
            shd_val_nxt = stg_val;
            shd_dp_nxt  = stg_dp;
            shd_en_nxt  = stg_en;
            pending_nxt = 1'b0;
            ack_nxt     = 1'b1;
        end

`ifdef LEADING_ZERO_BLANK_EN
        // Scan down from the top digit; a dp or a non-zero nibble ends the suppressed run.
        lz       = '0;
        zero_run = 1'b1;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            zero_run = zero_run && (shd_val_nxt[4*i +: 4] == 4'h0) && !shd_dp_nxt[i];
            lz[i]    = zero_run;
        end
        blank_dig = !shd_en_nxt[idx_nxt] || lz[idx_nxt];
`else
        blank_dig = !shd_en_nxt[idx_nxt];
`endif

        hex_nxt  = shd_val_nxt[{idx_nxt, 2'b00} +: 4];
        dp_n_nxt = blank_dig || !shd_dp_nxt[idx_nxt];
        an_nxt   = ((pcnt_nxt < BLANK_END) || blank_dig) ? '1 : ~(ONE_HOT0 << idx_nxt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt     <= '0;
            idx      <= '0;
            pending  <= 1'b0;
            stg_val  <= '0;
            stg_dp   <= '0;
            stg_en   <= '0;
            shd_val  <= '0;
            shd_dp   <= '0;
            shd_en   <= '0;
            load_ack <= 1'b0;
            hex_out  <= 4'h0;
            an       <= '1;
            dp_n     <= 1'b1;
        end else begin
            pcnt     <= pcnt_nxt;
            idx      <= idx_nxt;
            pending  <= pending_nxt;
            stg_val  <= stg_val_nxt;
            stg_dp   <= stg_dp_nxt;
            stg_en   <= stg_en_nxt;
            shd_val  <= shd_val_nxt;
            shd_dp   <= shd_dp_nxt;
            shd_en   <= shd_en_nxt;
            load_ack <= ack_nxt;
            hex_out  <= hex_nxt;
            an       <= an_nxt;
            dp_n     <= dp_n_nxt;
        end
    end
endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl at N_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1 (16-cycle frames).
module tb_disp_scan_ctrl;
    localparam int N = 4;
    localparam int R = 4;
    localparam int B = 1;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;
    logic        load;
    logic        load_ack;
    logic [3:0]  hex_out;
    logic [3:0]  an;
    logic        dp_n;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    disp_scan_ctrl #(
        .N_DIGITS    (N),
        .REFRESH_DIV (R),
        .BLANK_CYCLES(B)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .value   (value),
        .dp_in   (dp_in),
        .digit_en(digit_en),
        .load    (load),
        .load_ack(load_ack),
        .hex_out (hex_out),
        .an      (an),
        .dp_n    (dp_n)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks one full frame starting at frame cycle 0 against the expected shadow contents.
    // lit = digits expected to light; la/lb = frame cycles at which loads da/db ({value,dp,en}) are driven.
    task automatic frame(input string tag, input logic [15:0] sv, input logic [3:0] sdp,
                         input logic [3:0] lit, input bit ack1,
                         input int la, input logic [23:0] da, input int lb, input logic [23:0] db);
        for (int c = 0; c < 16; c++) begin
            int         d;
            logic [3:0] e_hex;
            logic [3:0] e_an;
            logic       e_dp;
            logic       e_ack;
            d     = c / 4;
            e_hex = 4'(sv >> (4 * d));
            e_an  = (((c % 4) < B) || !lit[d]) ? 4'hF : ~(4'b0001 << d);
            e_dp  = lit[d] ? ~sdp[d] : 1'b1;
            e_ack = ack1 && (c == 0);
            chk($sformatf("%s c%0d hex", tag, c), hex_out, e_hex);
            chk($sformatf("%s c%0d an", tag, c), an, e_an);
            chk($sformatf("%s c%0d dp_n", tag, c), dp_n, e_dp);
            chk($sformatf("%s c%0d ack", tag, c), load_ack, e_ack);
            if (c == la) begin
                {value, dp_in, digit_en} = da;
                load = 1'b1;
            end else if (c == lb) begin
                {value, dp_in, digit_en} = db;
                load = 1'b1;
            end else begin
                value    = 16'($urandom);
                dp_in    = 4'($urandom);
                digit_en = 4'($urandom);
                load     = 1'b0;
            end
            tick();
        end
        load = 1'b0;
    endtask

    initial begin
        value    = '0;
        dp_in    = '0;
        digit_en = '0;
        load     = 1'b0;

        #1 rst_n = 1'b0;
        #2;
        chk("reset an", an, 4'hF);
        chk("reset hex", hex_out, 4'h0);
        chk("reset dp_n", dp_n, 1'b1);
        chk("reset ack", load_ack, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Load during idx 1: nothing visible until the boundary, then one ack.
        frame("f0_dark", 16'h0000, 4'h0, 4'h0, 1'b0, 5, {16'h12AB, 4'b0100, 4'b1111}, -1, 24'h0);
        frame("f1_12ab", 16'h12AB, 4'b0100, 4'hF, 1'b1, -1, 24'h0, -1, 24'h0);

        // Stage a load, then reset mid-scan in digit 2's slot (hex 2, dp lit before reset).
        {value, dp_in, digit_en} = {16'h5555, 4'hF, 4'hF};
        load = 1'b1;
        tick();
        load = 1'b0;
        repeat (8) tick();
        chk("pre_rst hex", hex_out, 4'h2);
        chk("pre_rst dp_n", dp_n, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid an", an, 4'hF);
        chk("rst_mid hex", hex_out, 4'h0);
        chk("rst_mid dp_n", dp_n, 1'b1);
        chk("rst_mid ack", load_ack, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Pending load was discarded by reset; then a boundary-coincident bypass load.
        frame("f_post", 16'h0000, 4'h0, 4'h0, 1'b0, 15, {16'hC3D4, 4'b0001, 4'b1111}, -1, 24'h0);
        frame("f_byp", 16'hC3D4, 4'b0001, 4'hF, 1'b1, 15, {16'h0000, 4'b0000, 4'b1111}, -1, 24'h0);
        frame("f_zero", 16'h0000, 4'h0, LZB ? 4'b0001 : 4'b1111, 1'b1, -1, 24'h0, -1, 24'h0);
        // No leftover pending after the bypass; two loads staged in one frame.
        frame("f_zero2", 16'h0000, 4'h0, LZB ? 4'b0001 : 4'b1111, 1'b0,
              3, {16'h1111, 4'h0, 4'hF}, 10, {16'h2222, 4'h0, 4'hF});
        frame("f_two", 16'h2222, 4'h0, 4'hF, 1'b1, 6, {16'h89EF, 4'hF, 4'b0101}, -1, 24'h0);
        frame("f_en", 16'h89EF, 4'hF, 4'b0101, 1'b1, 8, {16'h0050, 4'h0, 4'hF}, -1, 24'h0);
        frame("f_lz", 16'h0050, 4'h0, LZB ? 4'b0011 : 4'b1111, 1'b1, -1, 24'h0, -1, 24'h0);
        frame("f_idle", 16'h0050, 4'h0, LZB ? 4'b0011 : 4'b1111, 1'b0, -1, 24'h0, -1, 24'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
